// File: rtl/display_pkg.sv
// Shared constants and FSM state type for the display arbiter.
// Frames are four 8-bit digit codes packed little-endian by digit index.
package display_pkg;

  localparam int DIGIT_W    = 8;
  localparam int NUM_DIGITS = 4;
  localparam int FRAME_W    = DIGIT_W * NUM_DIGITS;

  localparam logic [FRAME_W-1:0] FRAME_BLANK = 32'h0000_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Returns the first eligible
// requester above last_owner, wrapping to the lowest eligible index.
module rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_owner,
  input  logic [NUM_REQ-1:0] exclude,
  output logic               valid,
  output logic [IW-1:0]      index
);

  logic [NUM_REQ-1:0] elig;
  logic               hi_valid;
  logic [IW-1:0]      hi_index;
  logic [IW-1:0]      lo_index;

  assign elig  = req & ~exclude;
  assign valid = |elig;

  // Scanning downward lets the lowest matching index win in both searches.
  always_comb begin
    hi_valid = 1'b0;
    hi_index = '0;
    lo_index = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_index = IW'(i);
        if (i > int'(last_owner)) begin
          hi_valid = 1'b1;
          hi_index = IW'(i);
        end
      end
    end
  end

  assign index = hi_valid ? hi_index : lo_index;

endmodule

// File: rtl/display_arbiter.sv
// Time-sliced round-robin arbiter for a shared four-digit display.
// Define DISPLAY_ARB_BLANK_EN to blank the display while no one owns it.
module display_arbiter
  import display_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int SLICE_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*FRAME_W-1:0] req_digits,
  output logic [NUM_REQ-1:0]         grant,
  output logic [FRAME_W-1:0]         four_digits,
  output logic                       busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(SLICE_CYCLES);

  localparam logic [CW-1:0] SLICE_LAST = CW'(SLICE_CYCLES - 1);
  localparam logic [IW-1:0] OWNER_RST  = IW'(NUM_REQ - 1);

  // Handshake: req[i] is a level request; ownership is held while req[i]
  // stays high and is visible on grant one edge after req is sampled.
  arb_state_e           state, state_nx;
  logic [IW-1:0]        last_owner, last_owner_nx;
  logic [CW-1:0]        count, count_nx;
  logic [NUM_REQ-1:0]   grant_nx;
  logic [FRAME_W-1:0]   four_digits_nx;

  logic                 owner_req;
  logic [FRAME_W-1:0]   owner_frame;
  logic                 pick_valid;
  logic [IW-1:0]        pick_index;

  // In OWNED the grant vector is exactly the owner mask; in IDLE it is zero.
  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req        (req),
    .last_owner (last_owner),
    .exclude    (grant),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  // last_owner always names the current owner while OWNED.
  always_comb begin
    owner_req   = 1'b0;
    owner_frame = FRAME_BLANK;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_owner == IW'(i)) begin
        owner_req   = req[i];
        owner_frame = req_digits[FRAME_W*i +: FRAME_W];
      end
    end
  end

  always_comb begin
    state_nx       = state;
    last_owner_nx  = last_owner;
    count_nx       = count;
    grant_nx       = grant;
    four_digits_nx = four_digits;
    case (state)
      IDLE: begin
        count_nx = '0;
`ifdef DISPLAY_ARB_BLANK_EN
        four_digits_nx = FRAME_BLANK;
`endif
        if (pick_valid) begin
          state_nx             = OWNED;
          grant_nx             = '0;
          grant_nx[pick_index] = 1'b1;
          last_owner_nx        = pick_index;
        end
      end
      OWNED: begin
        four_digits_nx = owner_frame;
        if (!owner_req || (count == SLICE_LAST)) begin
          count_nx = '0;
          if (pick_valid) begin
            grant_nx             = '0;
            grant_nx[pick_index] = 1'b1;
            last_owner_nx        = pick_index;
          end else if (!owner_req) begin
            state_nx = IDLE;
            grant_nx = '0;
`ifdef DISPLAY_ARB_BLANK_EN
            four_digits_nx = FRAME_BLANK;
`endif
          end
        end else begin
          count_nx = count + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
        count_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_owner  <= OWNER_RST;
      count       <= '0;
      grant       <= '0;
      four_digits <= FRAME_BLANK;
    end else begin
      state       <= state_nx;
      last_owner  <= last_owner_nx;
      count       <= count_nx;
      grant       <= grant_nx;
      four_digits <= four_digits_nx;
    end
  end

  assign busy = |grant;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_REQ=2, SLICE_CYCLES=4.
module tb_display_arbiter;

  localparam logic [31:0] F0 = 32'h3F06_5B4F;
  localparam logic [31:0] F1 = 32'h6D7D_077F;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [63:0] req_digits;
  logic [1:0]  grant;
  logic [31:0] four_digits;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  display_arbiter #(
    .NUM_REQ      (2),
    .SLICE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_digits  (req_digits),
    .grant       (grant),
    .four_digits (four_digits),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One active edge, then settle to the sampling point on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] frame_of(input logic [1:0] g);
    return (g == 2'b10) ? F1 : F0;
  endfunction

  initial begin
    logic [1:0]  exp_g;
    logic [1:0]  prev_g;
    logic [31:0] exp_idle_frame;

    rst_n      = 1'b0;
    req        = 2'b00;
    req_digits = {F1, F0};
    repeat (2) @(negedge clk);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_digits", four_digits, 32'h0);
    check("rst_count", {30'd0, dut.count}, 32'd0);

    // First grant goes to requester 0; its frame lands one edge later.
    rst_n = 1'b1;
    req   = 2'b01;
    step();
    check("first_grant", {30'd0, grant}, 32'd1);
    check("first_busy", {31'd0, busy}, 32'd1);
    check("first_digits_lag", four_digits, 32'h0);
    step();
    check("first_digits", four_digits, F0);
    check("first_count", {30'd0, dut.count}, 32'd1);

    // Lone requester keeps the display across slice wraps.
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("solo_grant_%0d", k), {30'd0, grant}, 32'd1);
      check($sformatf("solo_count_%0d", k), {30'd0, dut.count}, 32'((1 + k) % 4));
      check($sformatf("solo_digits_%0d", k), four_digits, F0);
    end

    // Release with no other requester drops to IDLE.
`ifdef DISPLAY_ARB_BLANK_EN
    exp_idle_frame = 32'h0;
`else
    exp_idle_frame = F0;
`endif
    req = 2'b00;
    step();
    check("release_grant", {30'd0, grant}, 32'd0);
    check("release_busy", {31'd0, busy}, 32'd0);
    check("release_digits", four_digits, exp_idle_frame);
    check("release_count", {30'd0, dut.count}, 32'd0);
    step();
    step();
    check("idle_hold_digits", four_digits, exp_idle_frame);
    check("idle_hold_grant", {30'd0, grant}, 32'd0);

    // Fresh reset so requester 0 wins first with both requesting.
    rst_n = 1'b0;
    @(negedge clk);
    check("rst2_digits", four_digits, 32'h0);
    rst_n = 1'b1;
    req   = 2'b11;
    prev_g = 2'b00;
    for (int k = 0; k < 12; k++) begin
      step();
      exp_g = (((k / 4) % 2) == 0) ? 2'b01 : 2'b10;
      check($sformatf("rr_grant_%0d", k), {30'd0, grant}, {30'd0, exp_g});
      check($sformatf("rr_busy_%0d", k), {31'd0, busy}, 32'd1);
      check($sformatf("rr_count_%0d", k), {30'd0, dut.count}, 32'(k % 4));
      check($sformatf("rr_digits_%0d", k), four_digits, (k == 0) ? 32'h0 : frame_of(prev_g));
      prev_g = exp_g;
    end
    step();
    check("preempt_grant", {30'd0, grant}, 32'd2);
    check("preempt_count", {30'd0, dut.count}, 32'd0);
    check("preempt_digits_old", four_digits, F0);
    step();
    check("preempt_digits_new", four_digits, F1);
    check("preempt_count1", {30'd0, dut.count}, 32'd1);

    // Asynchronous reset while requester 1 owns mid-slice.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_grant", {30'd0, grant}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_digits", four_digits, 32'h0);
    check("async_count", {30'd0, dut.count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 2'b11;
    step();
    check("rearb_grant", {30'd0, grant}, 32'd1);
    step();
    check("rearb_count", {30'd0, dut.count}, 32'd1);
    check("rearb_digits", four_digits, F0);

    // Owner 0 drops mid-slice; handover to 1 with no idle gap.
    req = 2'b10;
    step();
    check("drop_grant", {30'd0, grant}, 32'd2);
    check("drop_busy", {31'd0, busy}, 32'd1);
    check("drop_count", {30'd0, dut.count}, 32'd0);
    check("drop_digits_old", four_digits, F0);
    step();
    check("drop_digits_new", four_digits, F1);
    check("drop_count1", {30'd0, dut.count}, 32'd1);
    step();
    step();
    check("expiry_count", {30'd0, dut.count}, 32'd3);

    // Owner release coinciding with slice expiry behaves as a release.
    req = 2'b01;
    step();
    check("rel_exp_grant", {30'd0, grant}, 32'd1);
    check("rel_exp_count", {30'd0, dut.count}, 32'd0);
    step();
    check("rel_exp_digits", four_digits, F0);

    req = 2'b00;
    step();
    check("final_grant", {30'd0, grant}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
